// File: rtl/detect_winner_seq.sv
// Sequential N x N win detector: scans one line per clock under a start/busy/done handshake.
// Optional macro DETECT_WINNER_EARLY_EXIT_EN stops the scan at the first winning line.
module detect_winner_seq #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*N-1:0]   ain,
    input  logic [N*N-1:0]   bin,
    output logic             busy,
    output logic             done,
    output logic [2*N+1:0]   win_line,
    output logic             win_a,
    output logic             win_b,
    output logic             draw,
    output logic             illegal
);

    localparam int NL = 2*N + 2;
    localparam int IW = $clog2(NL);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N*N-1:0]   a_q;
    logic [N*N-1:0]   b_q;
    logic [N*N-1:0]   mask;
    logic [IW-1:0]    idx;
    logic             hit_a;
    logic             hit_b;
    logic             last;
    int unsigned      li;
    logic             sel;

    // Cell mask of line idx: rows, then columns, then main and anti diagonal.
    always_comb begin
        mask = '0;
        sel  = 1'b0;
        li   = {{(32-IW){1'b0}}, idx};
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                if (li < N)
                    sel = (r == li);
                else if (li < 2*N)
                    sel = (c == li - N);
                else if (li == 2*N)
                    sel = (r == c);
                else
                    sel = (r + c == N - 1);
                if (sel)
                    mask[N*N-1-(r*N+c)] = 1'b1;
            end
        end
        hit_a = (a_q & mask) == mask;
        hit_b = (b_q & mask) == mask;
        last  = (idx == IW'(NL-1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
`ifdef DETECT_WINNER_EARLY_EXIT_EN
                if (last || hit_a || hit_b)
                    state_d = DONE;
`else
                if (last)
                    state_d = DONE;
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            win_line <= '0;
            win_a    <= 1'b0;
            win_b    <= 1'b0;
            draw     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= ain;
                        b_q      <= bin;
                        illegal  <= |(ain & bin);
                        win_line <= '0;
                        win_a    <= 1'b0;
                        win_b    <= 1'b0;
                        draw     <= 1'b0;
                        idx      <= '0;
                    end
                end
                SCAN: begin
                    win_line[idx] <= win_line[idx] | hit_a | hit_b;
                    win_a         <= win_a | hit_a;
                    win_b         <= win_b | hit_b;
                    idx           <= idx + IW'(1);
                    // Draw folds in the line judged on this same edge.
                    if (state_d == DONE)
                        draw <= (&(a_q | b_q)) && (win_line == '0) && !(hit_a || hit_b);
                end
                default: ;
            endcase
        end
    end

endmodule
